mem_bus_arbiter: RTL and testbench

//  Shares the single external memory bus between the instruction-fetch path and the

---
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// External memory bus between the arbiter (master) and the memory controller (slave).
// One request outstanding at a time; completion is a one-cycle bus_ack.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch and core data accesses,
// with fetch anti-starvation and a bus-ack timeout. All outputs are registered.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dat_rd_i,
  input  logic              dat_wr_i,
  input  logic [ADDR_W-1:0] dat_addr_i,
  input  logic [DATA_W-1:0] dat_wdata_i,
  output logic [DATA_W-1:0] dat_rdata_o,
  output logic              mem_busy_o,
  output logic              mem_ready_o,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ack_o,
  output logic [DATA_W-1:0] fetch_data_o,
  mem_bus_arbiter_if.master bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic        TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {IDLE, D_RD, D_WR, F_RD, D_DONE} state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_W-1:0]   dat_rdata_q, dat_rdata_d;
  logic                mem_busy_q, mem_busy_d;
  logic                mem_ready_q, mem_ready_d;
  logic                fetch_ack_q, fetch_ack_d;
  logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;

  logic              data_req;
  logic              fetch_win;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  // Fetch wins when data is idle or fetch has been passed over STARVE_MAX times.
  assign data_req  = dat_rd_i | dat_wr_i;
  assign fetch_win = fetch_req_i & (~data_req | (starve_q == STARVE_W'(STARVE_MAX)));
  // A real ack on the expiry edge takes precedence over the abort.
  assign expire    = TO_EN & ~bus.bus_ack & (wait_q == WAIT_W'(TO_LAST));
  assign done      = bus.bus_ack | expire;
  assign rsp_data  = bus.bus_ack ? bus.bus_rdata : {DATA_W{1'b1}};

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_err   = bus_err_q;
  assign dat_rdata_o   = dat_rdata_q;
  assign mem_busy_o    = mem_busy_q;
  assign mem_ready_o   = mem_ready_q;
  assign fetch_ack_o   = fetch_ack_q;
  assign fetch_data_o  = fetch_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      wait_q       <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_err_q    <= 1'b0;
      dat_rdata_q  <= '0;
      mem_busy_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      fetch_ack_q  <= 1'b0;
      fetch_data_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_err_q    <= bus_err_d;
      dat_rdata_q  <= dat_rdata_d;
      mem_busy_q   <= mem_busy_d;
      mem_ready_q  <= mem_ready_d;
      fetch_ack_q  <= fetch_ack_d;
      fetch_data_q <= fetch_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_err_d    = 1'b0;
    dat_rdata_d  = dat_rdata_q;
    mem_busy_d   = mem_busy_q;
    mem_ready_d  = 1'b0;
    fetch_ack_d  = 1'b0;
    fetch_data_d = fetch_data_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_win) begin
          state_d    = F_RD;
          bus_addr_d = fetch_addr_i;
          bus_we_d   = 1'b0;
          bus_req_d  = 1'b1;
          mem_busy_d = 1'b1;
          wait_d     = '0;
          starve_d   = '0;
        end else if (data_req) begin
          state_d     = dat_wr_i ? D_WR : D_RD;
          bus_addr_d  = dat_addr_i;
          bus_wdata_d = dat_wdata_i;
          bus_we_d    = dat_wr_i;
          bus_req_d   = 1'b1;
          mem_busy_d  = 1'b1;
          wait_d      = '0;
          if (!fetch_req_i)
            starve_d = '0;
          else if (starve_q != STARVE_W'(STARVE_MAX))
            starve_d = starve_q + STARVE_W'(1);
        end else begin
          starve_d = '0;
        end
      end
      D_RD, D_WR, F_RD: begin
        if (done) begin
          bus_req_d  = 1'b0;
          mem_busy_d = 1'b0;
          bus_err_d  = expire;
          state_d    = IDLE;
          if (state_q == D_RD) begin
            dat_rdata_d = rsp_data;
            mem_ready_d = 1'b1;
            state_d     = D_DONE;
          end else if (state_q == F_RD) begin
            fetch_data_d = rsp_data;
            fetch_ack_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned SM = 4;
  localparam int unsigned TO = 8;

  localparam logic [1:0] K_RD = 2'd0;
  localparam logic [1:0] K_WR = 2'd1;
  localparam logic [1:0] K_F  = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dat_rd = 1'b0;
  logic          dat_wr = 1'b0;
  logic [AW-1:0] dat_addr = '0;
  logic [DW-1:0] dat_wdata = '0;
  logic [DW-1:0] dat_rdata;
  logic          mem_busy;
  logic          mem_ready;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ack;
  logic [DW-1:0] fetch_data;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dat_rd_i     (dat_rd),
    .dat_wr_i     (dat_wr),
    .dat_addr_i   (dat_addr),
    .dat_wdata_i  (dat_wdata),
    .dat_rdata_o  (dat_rdata),
    .mem_busy_o   (mem_busy),
    .mem_ready_o  (mem_ready),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (fetch_addr),
    .fetch_ack_o  (fetch_ack),
    .fetch_data_o (fetch_data),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: acks ack_delay cycles after bus_req is first seen high.
  int            ack_delay = 1;
  logic          no_ack = 1'b0;
  logic [DW-1:0] resp = '0;
  initial begin
    int age;
    age = 0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_req) begin
        age++;
        if (age == ack_delay && !no_ack) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = resp;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Transaction-level model: one outstanding request, a done-cycle after reads.
  typedef struct packed {
    logic          inflight;
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [7:0]    age;
    logic [3:0]    starve;
    logic          ready;
    logic          err;
    logic          fack;
    logic [DW-1:0] rdata;
    logic [DW-1:0] fdata;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t s);
    model_t n;
    logic   hit, expire, data_req;
    n = s;
    n.ready = 1'b0;
    n.err   = 1'b0;
    n.fack  = 1'b0;
    data_req = dat_rd | dat_wr;
    if (s.inflight) begin
      hit    = bus_if.bus_ack;
      expire = !hit && (s.age == 8'(TO - 1));
      if (hit || expire) begin
        n.inflight = 1'b0;
        n.err      = expire;
        if (s.kind == K_RD) begin
          n.ready = 1'b1;
          n.rdata = hit ? bus_if.bus_rdata : 16'hFFFF;
        end else if (s.kind == K_F) begin
          n.fack  = 1'b1;
          n.fdata = hit ? bus_if.bus_rdata : 16'hFFFF;
        end
      end else begin
        n.age = s.age + 8'd1;
      end
    end else if (!s.ready) begin
      if (fetch_req && (!data_req || s.starve == 4'(SM))) begin
        n.inflight = 1'b1; n.kind = K_F; n.addr = fetch_addr; n.we = 1'b0;
        n.age = '0; n.starve = '0;
      end else if (data_req) begin
        n.inflight = 1'b1; n.kind = dat_wr ? K_WR : K_RD;
        n.addr = dat_addr; n.wdata = dat_wdata; n.we = dat_wr; n.age = '0;
        n.starve = !fetch_req ? 4'd0 : (s.starve < 4'(SM)) ? s.starve + 4'd1 : 4'(SM);
      end else begin
        n.starve = '0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m);
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("bus_req",    bus_if.bus_req,   m.inflight);
        chk("mem_busy",   mem_busy,         m.inflight);
        chk("bus_we",     bus_if.bus_we,    m.we);
        chk("bus_addr",   bus_if.bus_addr,  m.addr);
        chk("bus_wdata",  bus_if.bus_wdata, m.wdata);
        chk("mem_ready",  mem_ready,        m.ready);
        chk("bus_err",    bus_if.bus_err,   m.err);
        chk("fetch_ack",  fetch_ack,        m.fack);
        chk("dat_rdata",  dat_rdata,        m.rdata);
        chk("fetch_data", fetch_data,       m.fdata);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_read(input logic [AW-1:0] a, output int cyc, output logic got,
                          output logic err_seen);
    dat_rd = 1'b1; dat_addr = a;
    @(negedge clk);
    dat_rd = 1'b0;
    cyc = 0; got = 1'b0; err_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      err_seen = err_seen | bus_if.bus_err;
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
      cyc += int'(mem_busy);
      @(negedge clk);
    end
  endtask

  initial begin
    int   cyc, n_rd;
    logic got, err_seen, ready_seen, we_ok;

    // Reset values
    idle(2);
    chk("rst_bus_req",   bus_if.bus_req, 0);
    chk("rst_mem_busy",  mem_busy, 0);
    chk("rst_dat_rdata", dat_rdata, 0);
    chk("rst_bus_addr",  bus_if.bus_addr, 0);
    rst_n = 1'b1;
    idle(2);

    // Data read, ack three cycles after bus_req
    ack_delay = 3; resp = 16'hBEEF;
    run_read(16'h0040, cyc, got, err_seen);
    chk("rd_got",      got, 1);
    chk("rd_busy_cyc", cyc, 3);
    chk("rd_data",     dat_rdata, 16'hBEEF);
    chk("rd_no_err",   err_seen, 0);
    @(negedge clk);
    chk("rd_ready_one", mem_ready, 0);
    idle(2);

    // Posted write
    ack_delay = 2;
    dat_wr = 1'b1; dat_addr = 16'h0100; dat_wdata = 16'h1234;
    @(negedge clk);
    dat_wr = 1'b0;
    cyc = 0; ready_seen = 1'b0; we_ok = 1'b1;
    while (mem_busy && cyc < 30) begin
      we_ok = we_ok & bus_if.bus_we & (bus_if.bus_addr == 16'h0100) & (bus_if.bus_wdata == 16'h1234);
      ready_seen = ready_seen | mem_ready;
      cyc++;
      @(negedge clk);
    end
    chk("wr_stable",   we_ok, 1);
    chk("wr_busy_cyc", cyc, 2);
    chk("wr_no_ready", ready_seen | mem_ready, 0);
    idle(2);

    // Contention: fetch forced after STARVE_MAX data grants
    ack_delay = 1; resp = 16'hCAFE;
    fetch_req = 1'b1; fetch_addr = 16'h0200;
    dat_rd = 1'b1; dat_addr = 16'h0080;
    n_rd = 0; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_ready) n_rd++;
      if (fetch_ack) begin
        got = 1'b1;
        break;
      end
    end
    fetch_req = 1'b0; dat_rd = 1'b0;
    chk("ct_fetch_got", got, 1);
    chk("ct_data_grants", n_rd, 4);
    chk("ct_fetch_data", fetch_data, 16'hCAFE);
    idle(2);

    // Timeout abort
    no_ack = 1'b1;
    run_read(16'h0300, cyc, got, err_seen);
    chk("to_got",      got, 1);
    chk("to_busy_cyc", cyc, 8);
    chk("to_err",      err_seen, 1);
    chk("to_data",     dat_rdata, 16'hFFFF);
    no_ack = 1'b0;
    idle(2);

    // Ack on the timeout edge
    ack_delay = 8; resp = 16'h5A5A;
    run_read(16'h0310, cyc, got, err_seen);
    chk("col_got",      got, 1);
    chk("col_busy_cyc", cyc, 8);
    chk("col_no_err",   err_seen, 0);
    chk("col_data",     dat_rdata, 16'h5A5A);
    idle(2);

    // Asynchronous reset in the middle of a read
    no_ack = 1'b1;
    dat_rd = 1'b1; dat_addr = 16'h0400;
    @(negedge clk);
    dat_rd = 1'b0;
    chk("ar_req_before", bus_if.bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_bus_req",   bus_if.bus_req, 0);
    chk("ar_mem_busy",  mem_busy, 0);
    chk("ar_mem_ready", mem_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; no_ack = 1'b0;
    @(negedge clk);
    chk("ar_idle_busy", mem_busy, 0);
    ack_delay = 1; resp = 16'h1111;
    run_read(16'h0500, cyc, got, err_seen);
    chk("ar_rd_got",  got, 1);
    chk("ar_rd_cyc",  cyc, 1);
    chk("ar_rd_data", dat_rdata, 16'h1111);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
